// File: rtl/first_nios2_system_sysid_checker.sv
// first_nios2_system_sysid_checker
// Avalon-MM read master that fetches the system-ID slave's ID word (address 0)
// and timestamp word (address 1), compares them with the build-time values and
// reports pass/fail/timeout. All outputs are registered.
// Optional feature macro: SYSID_CHECK_RETRY_EN (re-run a failed check up to
// RETRY_LIMIT extra times before reporting).
// Handshake: a read completes in the cycle where read=1 and waitrequest=0;
// waitrequest is ignored while read=0, and read only drops mid-transfer on a
// timeout abort (or reset).
module first_nios2_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd7,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1383705343,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          RETRY_LIMIT        = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        RD_TS = 3'd2,
        EVAL  = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        read_d, address_d, busy_d, done_d, pass_d, timeout_d;
    logic [31:0] id_d, ts_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic        rd_ack, rd_stall, tmo_hit, match, can_retry;

    assign rd_ack    = read && !waitrequest;
    assign rd_stall  = read && waitrequest;
    assign tmo_hit   = rd_stall && (tcnt_q == TMO_LAST);
    assign match     = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);
    assign dbg_state = state_q;

`ifdef SYSID_CHECK_RETRY_EN
    logic [7:0] retry_q, retry_d;
    assign can_retry = (retry_q < 8'(RETRY_LIMIT));

    // Attempt counter: cleared on accepted start, bumped on each retry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) retry_q <= '0;
        else          retry_q <= retry_d;
    end
`else
    // Retry disabled: the limit only appears in a constant-false term.
    assign can_retry = 1'b0 && (RETRY_LIMIT > 0);
`endif

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            read     <= 1'b0;
            address  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            read     <= read_d;
            address  <= address_d;
            busy     <= busy_d;
            done     <= done_d;
            pass     <= pass_d;
            timeout  <= timeout_d;
            id_value <= id_d;
            ts_value <= ts_d;
            tcnt_q   <= tcnt_d;
        end
    end

    // Next-state and next-output logic; a read=0 cycle inside RD_ID/RD_TS is
    // the single idle gap before that state's read strobe goes up.
    always_comb begin
        state_d   = state_q;
        read_d    = read;
        address_d = address;
        busy_d    = busy;
        done_d    = 1'b0;
        pass_d    = pass;
        timeout_d = timeout;
        id_d      = id_value;
        ts_d      = ts_value;
        tcnt_d    = tcnt_q;
`ifdef SYSID_CHECK_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RD_ID;
                    read_d    = 1'b1;
                    address_d = 1'b0;
                    busy_d    = 1'b1;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    tcnt_d    = '0;
`ifdef SYSID_CHECK_RETRY_EN
                    retry_d   = '0;
`endif
                end
            end
            RD_ID, RD_TS: begin
                if (!read) begin
                    read_d = 1'b1;
                end else if (rd_ack) begin
                    read_d = 1'b0;
                    tcnt_d = '0;
                    if (state_q == RD_ID) begin
                        id_d      = readdata;
                        address_d = 1'b1;
                        state_d   = RD_TS;
                    end else begin
                        ts_d    = readdata;
                        state_d = EVAL;
                    end
                end else if (tmo_hit) begin
                    read_d = 1'b0;
                    tcnt_d = '0;
                    if (can_retry) begin
                        address_d = 1'b0;
                        state_d   = RD_ID;
`ifdef SYSID_CHECK_RETRY_EN
                        retry_d   = retry_q + 8'd1;
`endif
                    end else begin
                        timeout_d = 1'b1;
                        pass_d    = 1'b0;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = FIN;
                    end
                end else if (rd_stall) begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            EVAL: begin
                if (!match && can_retry) begin
                    address_d = 1'b0;
                    tcnt_d    = '0;
                    state_d   = RD_ID;
`ifdef SYSID_CHECK_RETRY_EN
                    retry_d   = retry_q + 8'd1;
`endif
                end else begin
                    pass_d  = match;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FIN;
                end
            end
            FIN: begin
                address_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                read_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Testbench for first_nios2_system_sysid_checker: table of directed checks
// plus hand-written sequences for start-while-busy, reset mid-read and
// (when SYSID_CHECK_RETRY_EN is defined) the retry behaviour.
module tb_first_nios2_system_sysid_checker;

    localparam logic [31:0] GOOD_ID = 32'd7;
    localparam logic [31:0] GOOD_TS = 32'd1383705343;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        address, read, waitrequest;
    logic [31:0] readdata;
    logic        busy, done, pass, timeout;
    logic [31:0] id_value, ts_value;
    logic [2:0]  dbg_state;

    // Slave model controls (written only by the stimulus process).
    logic [31:0] id_rsp = GOOD_ID;
    logic [31:0] ts_rsp = GOOD_TS;
    int          wait_id = 0;
    int          ts_bad = 0;       // number of leading wrong timestamp reads

    // Slave model bookkeeping (written only by the slave process).
    int stall_cnt = 0;
    int id_reads = 0;
    int ts_reads = 0;
    int done_cnt = 0;
    int ts_base = 0;

    int errors = 0;
    int checks = 0;

    first_nios2_system_sysid_checker dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .address     (address),
        .read        (read),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .id_value    (id_value),
        .ts_value    (ts_value),
        .dbg_state   (dbg_state)
    );

    // Clock.
    always #5 clock = ~clock;

    // Slave: stalls the ID read for wait_id cycles, answers by address.
    assign waitrequest = read && !address && (stall_cnt < wait_id);
    assign readdata    = address ? (((ts_reads - ts_base) < ts_bad) ? ~ts_rsp : ts_rsp) : id_rsp;

    always @(posedge clock) begin
        if (!read || address) stall_cnt <= 0;
        else if (waitrequest) stall_cnt <= stall_cnt + 1;
        if (read && !waitrequest && !address) id_reads <= id_reads + 1;
        if (read && !waitrequest && address)  ts_reads <= ts_reads + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, got, got, exp, exp);
        end
    endtask

    // Pulse start, wait (bounded) for done; returns cycle at which done seen.
    task automatic run_check(output int lat);
        lat = -1;
        @(negedge clock);
        ts_base = ts_reads;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            if (c == 1) chk("busy_cycle1", {31'd0, busy}, 32'd1);
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clock);
        end
        if (lat < 0) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: no done within 600 cycles");
        end
    endtask

    typedef struct {
        logic [31:0] id_rsp;
        logic [31:0] ts_rsp;
        int          wait_id;
        logic        exp_pass;
        logic        exp_timeout;
        logic [31:0] exp_id;
        logic [31:0] exp_ts;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];
    int   lat;
    int   dn0, idr0;

    initial begin
        // Expectations carried across rows: a timeout keeps the prior captures.
        vecs[0] = '{GOOD_ID,  GOOD_TS,        0,   1'b1, 1'b0, GOOD_ID, GOOD_TS,        5};
        vecs[1] = '{32'd8,    GOOD_TS,        0,   1'b0, 1'b0, 32'd8,   GOOD_TS,        5};
        vecs[2] = '{GOOD_ID,  GOOD_TS,        0,   1'b1, 1'b0, GOOD_ID, GOOD_TS,        5};
        vecs[3] = '{GOOD_ID,  32'd1383705344, 0,   1'b0, 1'b0, GOOD_ID, 32'd1383705344, 5};
        vecs[4] = '{GOOD_ID,  GOOD_TS,        254, 1'b1, 1'b0, GOOD_ID, GOOD_TS,        259};
        vecs[5] = '{32'd9,    32'd1,          255, 1'b0, 1'b1, GOOD_ID, GOOD_TS,        256};
        vecs[6] = '{32'd0,    32'd0,          0,   1'b0, 1'b0, 32'd0,   32'd0,          5};

        // Reset.
        repeat (3) @(negedge clock);
        chk("rst_read",    {31'd0, read},    32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_done",    {31'd0, done},    32'd0);
        chk("rst_pass",    {31'd0, pass},    32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_id",      id_value,         32'd0);
        chk("rst_ts",      ts_value,         32'd0);
        chk("rst_state",   {29'd0, dbg_state}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Table-driven checks.
        for (int i = 0; i < 7; i++) begin
            id_rsp  = vecs[i].id_rsp;
            ts_rsp  = vecs[i].ts_rsp;
            wait_id = vecs[i].wait_id;
            run_check(lat);
            chk($sformatf("v%0d_latency", i), lat,                    vecs[i].exp_lat);
            chk($sformatf("v%0d_pass", i),    {31'd0, pass},          {31'd0, vecs[i].exp_pass});
            chk($sformatf("v%0d_timeout", i), {31'd0, timeout},       {31'd0, vecs[i].exp_timeout});
            chk($sformatf("v%0d_id", i),      id_value,               vecs[i].exp_id);
            chk($sformatf("v%0d_ts", i),      ts_value,               vecs[i].exp_ts);
            chk($sformatf("v%0d_read", i),    {31'd0, read},          32'd0);
            @(negedge clock);
            chk($sformatf("v%0d_done_1cyc", i), {31'd0, done},        32'd0);
            repeat (2) @(negedge clock);
        end

        // start re-pulsed while busy and in the done cycle: one done only.
        id_rsp = GOOD_ID; ts_rsp = GOOD_TS; wait_id = 0;
        dn0 = done_cnt;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);                       // cycle 2
        start = 1'b1;
        @(negedge clock);                       // cycle 3
        start = 1'b0;
        @(negedge clock);                       // cycle 4
        @(negedge clock);                       // cycle 5: done
        chk("busy_seq_done", {31'd0, done}, 32'd1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (12) @(negedge clock);
        chk("busy_seq_done_count", done_cnt - dn0, 32'd1);
        chk("busy_seq_idle",       {31'd0, busy},  32'd0);
        chk("busy_seq_pass",       {31'd0, pass},  32'd1);

        // Reset asserted while the timestamp read is on the bus.
        dn0 = done_cnt;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);            // cycle 3: RD_TS read
        chk("rst_mid_read_before", {31'd0, read, address}, 32'd3);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_read",  {31'd0, read},  32'd0);
        chk("rst_mid_busy",  {31'd0, busy},  32'd0);
        chk("rst_mid_id",    id_value,       32'd0);
        chk("rst_mid_ts",    ts_value,       32'd0);
        chk("rst_mid_state", {29'd0, dbg_state}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        chk("rst_mid_no_done", done_cnt - dn0, 32'd0);
        chk("rst_mid_read_idle", {31'd0, read}, 32'd0);

`ifdef SYSID_CHECK_RETRY_EN
        // Timestamp wrong twice, then right: three ID reads, pass.
        idr0 = id_reads;
        ts_bad = 2;
        run_check(lat);
        chk("retry_ok_id_reads", id_reads - idr0, 32'd3);
        chk("retry_ok_pass",     {31'd0, pass},   32'd1);
        repeat (3) @(negedge clock);
        // Always wrong: four attempts, fail.
        idr0 = id_reads;
        ts_bad = 100;
        run_check(lat);
        chk("retry_bad_id_reads", id_reads - idr0, 32'd4);
        chk("retry_bad_pass",     {31'd0, pass},   32'd0);
        ts_bad = 0;
`else
        idr0 = id_reads;
        ts_bad = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
